// File: rtl/gpu_spi_pkg.sv
// Shared frame geometry and FSM state encoding for the SPI command target.
package gpu_spi_pkg;

    localparam int unsigned SPI_FRAME_BITS = 72;
    localparam int unsigned SPI_HDR_BITS   = 8;
    localparam int unsigned SPI_ADDR_W     = 7;
    localparam int unsigned SPI_DATA_W     = 64;

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        HDR,
        RD_ISSUE,
        DATA,
        WR_ISSUE
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with single-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 target turning 72-bit host frames into register read/write commands.
// Optional SPI_FRAME_ERR_CNT_EN adds a saturating aborted-frame counter output.
module spi_cmd_slave
    import gpu_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = SPI_ADDR_W,
    parameter int unsigned DATA_W      = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_rw,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_rdata,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef SPI_FRAME_ERR_CNT_EN
    ,
    output logic [7:0]        frame_err_cnt
`endif
);

    localparam int unsigned HDR_BITS   = ADDR_W + 1;
    localparam int unsigned FRAME_BITS = HDR_BITS + DATA_W;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] HDR_DONE   = CNT_W'(HDR_BITS);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sclk),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_cs_n),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_mosi),
        .q    (mosi_q),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    // Framing works on synced levels; the edge strobes below are not needed.
    logic unused_edges;
    assign unused_edges = ^{sclk_q, cs_rise, cs_fall, mosi_rise, mosi_fall};

    spi_state_e              state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt;
    logic [HDR_BITS-1:0]     hdr_sr;
    logic [DATA_W-1:0]       data_sr;
    logic [DATA_W-1:0]       tx_sr;
    logic                    wr_pend;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;

    logic cnt_clr, hdr_shift, data_shift, tx_load, tx_shift;
    logic wr_load, wr_drop, rd_fire, abort;
    logic rd;

    assign rd = hdr_sr[HDR_BITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_CS;
        end else begin
            state_q <= state_d;
        end
    end

    // Synced CS high is checked before any SCLK edge so an abort always wins.
    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        hdr_shift  = 1'b0;
        data_shift = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        wr_load    = 1'b0;
        wr_drop    = 1'b0;
        rd_fire    = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            WAIT_CS: begin
                if (cs_q) state_d = IDLE;
            end
            IDLE: begin
                if (!cs_q) begin
                    state_d = HDR;
                    cnt_clr = 1'b1;
                end
            end
            HDR: begin
                if (cs_q) begin
                    state_d = IDLE;
                    abort   = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    hdr_shift = 1'b1;
                    if (bit_cnt == HDR_LAST) begin
                        state_d = hdr_sr[HDR_BITS-2] ? RD_ISSUE : DATA;
                    end
                end
            end
            RD_ISSUE: begin
                if (cs_q) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else begin
                    data_shift = sclk_rise;
                    if (!wr_pend) begin
                        rd_fire = 1'b1;
                        tx_load = 1'b1;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (cs_q) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else begin
                    if (sclk_rise) begin
                        data_shift = 1'b1;
                        if (bit_cnt >= FRAME_LAST) begin
                            if (rd) begin
                                state_d = WAIT_CS;
                            end else begin
                                state_d = WR_ISSUE;
                                wr_load = !wr_pend || cmd_ready;
                                wr_drop = wr_pend && !cmd_ready;
                            end
                        end
                    end
                    // The fall right after the header presents tx[msb]; shifting starts one fall later.
                    tx_shift = sclk_fall && rd && (bit_cnt > HDR_DONE);
                end
            end
            WR_ISSUE: begin
                state_d = WAIT_CS;
            end
            default: begin
                state_d = WAIT_CS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            hdr_sr  <= '0;
            data_sr <= '0;
            tx_sr   <= '0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            overrun <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (hdr_shift || data_shift) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (hdr_shift) hdr_sr <= {hdr_sr[HDR_BITS-2:0], mosi_q};
            if (data_shift) data_sr <= {data_sr[DATA_W-2:0], mosi_q};

            if (tx_load) begin
                tx_sr <= cmd_ready ? cmd_rdata : '0;
            end else if (tx_shift) begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end

            if (wr_load) begin
                wr_pend <= 1'b1;
                wr_addr <= hdr_sr[ADDR_W-1:0];
                wr_data <= {data_sr[DATA_W-2:0], mosi_q};
            end else if (cmd_ready) begin
                wr_pend <= 1'b0;
            end

            if (wr_drop || (rd_fire && !cmd_ready)) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef SPI_FRAME_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || overrun_clr) begin
            frame_err_cnt <= '0;
        end else if (abort && (frame_err_cnt != 8'hFF)) begin
            frame_err_cnt <= frame_err_cnt + 8'd1;
        end
    end
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

    assign cmd_valid = wr_pend || rd_fire;
    assign cmd_rw    = rd_fire && !wr_pend;
    assign cmd_addr  = wr_pend ? wr_addr : (rd_fire ? hdr_sr[ADDR_W-1:0] : '0);
    assign cmd_wdata = wr_pend ? wr_data : '0;
    assign spi_miso  = (state_q == DATA) && rd && tx_sr[DATA_W-1];
    assign busy      = !(state_q inside {IDLE, WAIT_CS}) || wr_pend;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench for spi_cmd_slave: writes, reads, aborts, overrun and mid-frame reset.
module tb_spi_cmd_slave;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic        cmd_rw;
    logic [6:0]  cmd_addr;
    logic [63:0] cmd_wdata;
    logic [63:0] cmd_rdata = 64'h6702;
    logic        busy;
    logic        overrun;
    logic        overrun_clr = 1'b0;
`ifdef SPI_FRAME_ERR_CNT_EN
    logic [7:0]  frame_err_cnt;
`endif

    always #5 clk = ~clk;

    spi_cmd_slave #(.SYNC_STAGES(2), .ADDR_W(7), .DATA_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_rdata   (cmd_rdata),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef SPI_FRAME_ERR_CNT_EN
        ,
        .frame_err_cnt (frame_err_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          hs_cnt = 0;
    int          rd_valid_cycles = 0;
    logic        last_rw = 1'b0;
    logic [6:0]  last_addr = '0;
    logic [63:0] last_wdata = '0;

    always @(negedge clk) begin
        if (!rst && cmd_valid) begin
            if (cmd_rw) rd_valid_cycles++;
            if (cmd_ready) begin
                hs_cnt++;
                last_rw    = cmd_rw;
                last_addr  = cmd_addr;
                last_wdata = cmd_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [71:0] frame, input int nbits, output logic [71:0] rx);
        rx = '0;
        spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = frame[71-i];
            #HALF;
            rx[71-i] = spi_miso;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        #HALF;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #(4*HALF);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 cmd_ready = v;
    endtask

    task automatic pulse_clr;
        @(posedge clk);
        #1 overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        @(negedge clk);
    endtask

    logic [71:0] rx;
    int          hs0, rd0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 72'(cmd_valid), 72'(0));
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_miso", 72'(spi_miso), 72'(0));
        check("rst_overrun", 72'(overrun), 72'(0));
        check("rst_addr", 72'(cmd_addr), 72'(0));
        rst = 1'b0;
        repeat (10) @(negedge clk);

        hs0 = hs_cnt;
        spi_xfer({8'h02, 64'h0000_0001_0020_0010}, 72, rx);
        check("wr_hs", 72'(hs_cnt - hs0), 72'(1));
        check("wr_rw", 72'(last_rw), 72'(0));
        check("wr_addr", 72'(last_addr), 72'(7'h02));
        check("wr_data", 72'(last_wdata), 72'(64'h0000_0001_0020_0010));
        check("wr_overrun", 72'(overrun), 72'(0));

        hs0 = hs_cnt;
        rd0 = rd_valid_cycles;
        spi_xfer({8'hFF, 64'hDEAD_BEEF_0000_1111}, 72, rx);
        check("rd_hs", 72'(hs_cnt - hs0), 72'(1));
        check("rd_valid_cycles", 72'(rd_valid_cycles - rd0), 72'(1));
        check("rd_rw", 72'(last_rw), 72'(1));
        check("rd_addr", 72'(last_addr), 72'(7'h7F));
        check("rd_miso", 72'(rx[63:0]), 72'(64'h6702));

        hs0 = hs_cnt;
        spi_xfer({8'h05, 64'h1122_3344_5566_7788}, 40, rx);
        check("abort_hs", 72'(hs_cnt - hs0), 72'(0));
        check("abort_busy", 72'(busy), 72'(0));
`ifdef SPI_FRAME_ERR_CNT_EN
        check("abort_err_cnt", 72'(frame_err_cnt), 72'(1));
`endif
        spi_xfer({8'h05, 64'h1122_3344_5566_7788}, 72, rx);
        check("post_abort_hs", 72'(hs_cnt - hs0), 72'(1));
        check("post_abort_addr", 72'(last_addr), 72'(7'h05));
        check("post_abort_data", 72'(last_wdata), 72'(64'h1122_3344_5566_7788));

        set_ready(1'b0);
        hs0 = hs_cnt;
        spi_xfer({8'h10, 64'hA5A5_0000_FFFF_1234}, 72, rx);
        check("hold_valid1", 72'(cmd_valid), 72'(1));
        check("hold_addr1", 72'(cmd_addr), 72'(7'h10));
        check("hold_busy", 72'(busy), 72'(1));
        spi_xfer({8'h11, 64'h0F0F_0F0F_0F0F_0F0F}, 72, rx);
        check("hold_valid2", 72'(cmd_valid), 72'(1));
        check("hold_addr2", 72'(cmd_addr), 72'(7'h10));
        check("hold_data2", 72'(cmd_wdata), 72'(64'hA5A5_0000_FFFF_1234));
        check("ovr_set", 72'(overrun), 72'(1));
        set_ready(1'b1);
        repeat (20) @(negedge clk);
        check("ovr_hs", 72'(hs_cnt - hs0), 72'(1));
        check("ovr_first_data", 72'(last_wdata), 72'(64'hA5A5_0000_FFFF_1234));
        check("ovr_valid_idle", 72'(cmd_valid), 72'(0));
        pulse_clr();
        check("ovr_clr", 72'(overrun), 72'(0));
`ifdef SPI_FRAME_ERR_CNT_EN
        check("err_cnt_clr", 72'(frame_err_cnt), 72'(0));
`endif

        hs0 = hs_cnt;
        fork
            spi_xfer({8'h22, 64'h5555_6666_7777_8888}, 72, rx);
            begin
                #(60*HALF);
                rst = 1'b1;
                #20 rst = 1'b0;
            end
        join
        check("rstmid_hs", 72'(hs_cnt - hs0), 72'(0));
        check("rstmid_busy", 72'(busy), 72'(0));
        spi_xfer({8'h33, 64'hCAFE_F00D_1234_5678}, 72, rx);
        check("rstmid_next_hs", 72'(hs_cnt - hs0), 72'(1));
        check("rstmid_next_addr", 72'(last_addr), 72'(7'h33));
        check("rstmid_next_data", 72'(last_wdata), 72'(64'hCAFE_F00D_1234_5678));

        set_ready(1'b0);
        rd0 = rd_valid_cycles;
        spi_xfer({8'h85, 64'h0}, 72, rx);
        check("rdnr_miso", 72'(rx[63:0]), 72'(0));
        check("rdnr_overrun", 72'(overrun), 72'(1));
        check("rdnr_valid_cycles", 72'(rd_valid_cycles - rd0), 72'(1));
        set_ready(1'b1);
        pulse_clr();
        check("rdnr_clr", 72'(overrun), 72'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
